// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, line idle level and the
// receive bit-FSM state encoding.
package uart_pkg;

  // 50 MHz system clock / 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Serial line level while no frame is in flight (also the stop-bit level).
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Receive bit FSM.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchronizer, baud counter and bit
// FSM. byte_valid / stop_error are single-cycle pulses raised in the cycle
// whose closing edge samples the stop bit; byte_out is stable while they are.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stop_error
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_q;
  logic             rx_s_q;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= UART_IDLE_LEVEL;
      rx_s_q    <= UART_IDLE_LEVEL;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Bit FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: mid-bit start check, full-bit data/stop sampling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_error = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s_q != UART_IDLE_LEVEL) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (rx_s_q == UART_IDLE_LEVEL) begin
            // Glitch shorter than half a bit: not a real start.
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s_q == UART_IDLE_LEVEL) begin
            byte_valid = 1'b1;
          end else begin
            stop_error = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign byte_out = shift_q;

endmodule

// File: rtl/uart_rx_ram_loader.sv
// UART program loader: pairs received bytes into big-endian words and writes
// them to RAM addresses 0..WORD_COUNT-1, then raises a sticky load_done.
module uart_rx_ram_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned WORD_COUNT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              enable_ram,
  output logic              write_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic [DATA_W-1:0] data_to_ram,
  output logic              load_done,
  output logic              frame_error
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(WORD_COUNT - 1);

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_stop_err;

  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .stop_error(rx_stop_err)
  );

  // Word assembly, write strobe, address pointer and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: high byte first; the low byte issues a one-cycle write.
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    data_d  = data_q;
    done_d  = done_q;
    ferr_d  = ferr_q;

    // Pointer advances the cycle after a strobe and parks on the last word.
    if (we_q && (ptr_q != PTR_LAST)) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end

    if (rx_stop_err) begin
      // A bad frame also drops any half-assembled word.
      ferr_d  = 1'b1;
      phase_d = 1'b0;
    end else if (rx_valid) begin
      if (!phase_q) begin
        hi_d    = rx_byte;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (!done_q) begin
          we_d   = 1'b1;
          data_d = DATA_W'({hi_q, rx_byte});
          if (ptr_q == PTR_LAST) begin
            done_d = 1'b1;
          end
        end
      end
    end
  end

  assign write_enable_to_ram = we_q;
  assign enable_ram          = we_q;
  assign address_to_ram      = ptr_q;
  assign data_to_ram         = data_q;
  assign load_done           = done_q;
  assign frame_error         = ferr_q;

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// Self-checking bench for uart_rx_ram_loader: directed scenarios plus random
// byte streams, compared against a word-level reference model.
module tb_uart_rx_ram_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned WC  = 4;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 16;
  // Start-bit drive to strobe: 2 sync flops + 1 idle detect + half bit
  // + eight data bits + one stop bit.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          uart_rx;
  logic          enable_ram;
  logic          write_enable_to_ram;
  logic [AW-1:0] address_to_ram;
  logic [DW-1:0] data_to_ram;
  logic          load_done;
  logic          frame_error;

  uart_rx_ram_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WORD_COUNT  (WC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_rx            (uart_rx),
    .enable_ram         (enable_ram),
    .write_enable_to_ram(write_enable_to_ram),
    .address_to_ram     (address_to_ram),
    .data_to_ram        (data_to_ram),
    .load_done          (load_done),
    .frame_error        (frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
    int en;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];

  // Capture every observed write strobe away from the clock edge.
  always @(negedge clk) begin
    if (write_enable_to_ram === 1'b1)
      got_q.push_back('{int'(address_to_ram), int'(data_to_ram), cyc, int'(enable_ram)});
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes accepted since reset, grouped into words.
  int m_phase, m_hi, m_cnt, m_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = 0;
    m_hi    = 0;
    m_cnt   = 0;
    m_ferr  = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic hold_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    int start;
    @(posedge clk);
    #2;
    start = cyc;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_ok);
    uart_rx = 1'b1;
    if (!stop_ok) begin
      m_phase = 0;
      m_ferr  = 1;
      hold_bit(1'b1);  // let the receiver settle after a low stop bit
    end else if (m_phase == 0) begin
      m_hi    = int'(b);
      m_phase = 1;
    end else begin
      m_phase = 0;
      if (m_cnt < int'(WC))
        exp_q.push_back('{m_cnt, (m_hi << 8) | int'(b), start + LAT, 1});
      m_cnt++;
    end
  endtask

  task automatic false_start();
    @(posedge clk);
    #2;
    uart_rx = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    hold_bit(1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_writes(input string tag);
    repeat (4) @(posedge clk);
    #2;
    chk({tag, "_wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
      chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
      chk({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_ram_en"}, got_q[i].en, exp_q[i].en);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_load_done"}, load_done, (m_cnt >= int'(WC)) ? 1 : 0);
    chk({tag, "_frame_error"}, frame_error, m_ferr);
    chk({tag, "_address"}, address_to_ram, (m_cnt >= int'(WC)) ? int'(WC) - 1 : m_cnt);
    chk({tag, "_we_idle"}, write_enable_to_ram, 0);
  endtask

  initial begin
    logic [7:0] b;
    reset   = 1'b1;
    uart_rx = 1'b1;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_we", write_enable_to_ram, 0);
    chk("rst_en", enable_ram, 0);
    chk("rst_addr", address_to_ram, 0);
    chk("rst_data", data_to_ram, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ferr", frame_error, 0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    chk("rst_no_strobe", got_q.size(), 0);
    check_status("rst");

    // Single word.
    do_reset();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check_writes("single");
    check_status("single");

    // False start, then a good word.
    do_reset();
    false_start();
    check_writes("fstart_none");
    send_frame(8'hAB, 1'b1);
    send_frame(8'hCD, 1'b1);
    check_writes("fstart");
    check_status("fstart");

    // Frame error drops the pending byte.
    do_reset();
    send_frame(8'h55, 1'b0);
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    check_writes("ferr");
    check_status("ferr");

    // Full load, then extra bytes produce no writes.
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    check_writes("full");
    check_status("full");
    send_frame(8'hEE, 1'b1);
    send_frame(8'h11, 1'b1);
    check_writes("full_extra");
    check_status("full_extra");

    // Reset after the fourth data bit of a high byte.
    do_reset();
    b = 8'h5A;
    @(posedge clk);
    #2;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(b[i]);
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("midrst_addr", address_to_ram, 0);
    chk("midrst_we", write_enable_to_ram, 0);
    reset = 1'b0;
    model_clear();
    send_frame(8'h9A, 1'b1);
    send_frame(8'hBC, 1'b1);
    check_writes("midrst");
    check_status("midrst");

    // Random byte streams with occasional bad stop bits and glitches.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 5) == 0) false_start();
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 6) != 0));
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      check_writes("rand");
      check_status("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
